scan_mux_n: RTL and testbench

- Parametrised, registered N-to-1 channel multiplexer.
- Successor to the fixed 8x8-bit combinational selector; used in display and debug-output paths.
- Two modes: manual select, and an auto-scan mode driven by a programmable prescaler that steps round-robin through the enabled channels.
- Provides a registered data output, the current channel index, a one-hot channel strobe for digit/anode drive, and an advance pulse.

---
 rtl/scan_mux_n_pkg.sv | 14 +
 rtl/scan_mux_n_rr_next_sel.sv | 24 ++
 rtl/scan_mux_n.sv | 105 ++++++++++
 tb/tb_scan_mux_n.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_mux_n_pkg.sv
// rtl/scan_mux_n_pkg.sv - shared mode encodings and width helper for scan_mux_n
package scan_mux_n_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_AUTO   = 1'b1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/scan_mux_n_rr_next_sel.sv
// rtl/scan_mux_n_rr_next_sel.sv - circular priority search for the next enabled channel after cur
module rr_next_sel #(
   parameter int CHANNELS = 8,
   parameter int SEL_W    = 3
) (
   input  logic [SEL_W-1:0]    cur,
   input  logic [CHANNELS-1:0] mask,
   output logic [SEL_W-1:0]    next,
   output logic                found
);

   // Walk from the far end back toward cur+1 so the nearest enabled channel wins;
   // cur itself is the last candidate, so a lone enabled cur returns cur.
   always_comb begin
      next  = cur;
      found = |mask;
      for (int k = CHANNELS; k >= 1; k--) begin
         if (mask[(int'(cur) + k) % CHANNELS]) begin
            next = SEL_W'((int'(cur) + k) % CHANNELS);
         end
      end
   end

endmodule

// File: rtl/scan_mux_n.sv
// rtl/scan_mux_n.sv - registered N-to-1 channel mux with manual select and prescaled round-robin scan
module scan_mux_n
   import scan_mux_n_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 8,
   parameter int SEL_W    = 3,
   parameter int DIV_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel_in,
   input  logic [DIV_W-1:0]          div,
   input  logic [CHANNELS-1:0]       en_mask,
   input  logic [CHANNELS*WIDTH-1:0] din,
   output logic [WIDTH-1:0]          dout,
   output logic [SEL_W-1:0]          sel_out,
   output logic [CHANNELS-1:0]       chan_onehot,
   output logic                      adv
);

   if (SEL_W != clog2(CHANNELS) || CHANNELS < 2 || CHANNELS > 64) begin : g_bad_param
      $error("scan_mux_n: CHANNELS must be 2..64 and SEL_W must equal clog2(CHANNELS)");
   end

   localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);

   logic [DIV_W-1:0]    cnt, cnt_next;
   logic                blank, blank_next;
   logic [SEL_W-1:0]    sel_next;
   logic [SEL_W-1:0]    rr_next;
   logic                rr_found;
   logic [WIDTH-1:0]    lane [CHANNELS];
   logic [WIDTH-1:0]    dout_next;
   logic [CHANNELS-1:0] onehot_next;

   rr_next_sel #(
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
   ) u_rr (
      .cur   (sel_out),
      .mask  (en_mask),
      .next  (rr_next),
      .found (rr_found)
   );

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         lane[i] = din[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      sel_next   = sel_out;
      cnt_next   = cnt;
      blank_next = blank;
      if (mode == MODE_MANUAL) begin
         cnt_next   = '0;
         blank_next = 1'b0;
         if ({1'b0, sel_in} < CH_LIM) begin
            sel_next = sel_in;
         end
      end else begin
         // Blanking follows the mask immediately; the scan position only moves on a tick.
         blank_next = ~|en_mask;
         if (cnt >= div) begin
            cnt_next = '0;
            if (rr_found) begin
               sel_next = rr_next;
            end
         end else begin
            cnt_next = cnt + DIV_W'(1);
         end
      end
   end

   always_comb begin
      dout_next   = '0;
      onehot_next = '0;
      if (!blank_next) begin
         dout_next             = lane[sel_next];
         onehot_next[sel_next] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         blank       <= 1'b1;
         sel_out     <= '0;
         dout        <= '0;
         chan_onehot <= '0;
         adv         <= 1'b0;
      end else begin
         cnt         <= cnt_next;
         blank       <= blank_next;
         sel_out     <= sel_next;
         dout        <= dout_next;
         chan_onehot <= onehot_next;
         adv         <= (sel_next != sel_out);
      end
   end

endmodule

// File: tb/tb_scan_mux_n.sv
// tb/tb_scan_mux_n.sv - directed scoreboard bench for scan_mux_n
module tb_scan_mux_n;

   localparam int WIDTH    = 8;
   localparam int CHANNELS = 8;
   localparam int SEL_W    = 3;
   localparam int DIV_W    = 16;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      mode;
   logic [SEL_W-1:0]          sel_in;
   logic [DIV_W-1:0]          div;
   logic [CHANNELS-1:0]       en_mask;
   logic [CHANNELS*WIDTH-1:0] din;
   logic [WIDTH-1:0]          dout;
   logic [SEL_W-1:0]          sel_out;
   logic [CHANNELS-1:0]       chan_onehot;
   logic                      adv;

   scan_mux_n #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W),
      .DIV_W    (DIV_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mode        (mode),
      .sel_in      (sel_in),
      .div         (div),
      .en_mask     (en_mask),
      .din         (din),
      .dout        (dout),
      .sel_out     (sel_out),
      .chan_onehot (chan_onehot),
      .adv         (adv)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [7:0] dout;
      logic [2:0] sel;
      logic [7:0] oh;
      logic       adv;
      bit         chk_adv;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   seq [6];

   function automatic logic [7:0] lane_val(input int s);
      return 8'(8'hA0 + s);
   endfunction

   task automatic push_raw(input string tag, input int s, input logic [7:0] d,
                           input logic [7:0] oh, input logic a, input bit ca);
      exp_t e;
      e.tag     = tag;
      e.sel     = 3'(s);
      e.dout    = d;
      e.oh      = oh;
      e.adv     = a;
      e.chk_adv = ca;
      sb.push_back(e);
   endtask

   task automatic push(input string tag, input int s, input bit blank, input logic a, input bit ca);
      logic [7:0] one;
      one = 8'h01;
      push_raw(tag, s, blank ? 8'h00 : lane_val(s), blank ? 8'h00 : (one << s), a, ca);
   endtask

   task automatic check_pop();
      exp_t e;
      total++;
      assert (sb.size() > 0) else begin
         bad++;
         $error("FAIL scoreboard_empty got=%0d exp=>0", sb.size());
      end
      if (sb.size() == 0) return;
      e = sb.pop_front();
      total++;
      assert (dout === e.dout) else begin
         bad++;
         $error("FAIL %s dout got=%h exp=%h", e.tag, dout, e.dout);
      end
      total++;
      assert (sel_out === e.sel) else begin
         bad++;
         $error("FAIL %s sel_out got=%0d exp=%0d", e.tag, sel_out, e.sel);
      end
      total++;
      assert (chan_onehot === e.oh) else begin
         bad++;
         $error("FAIL %s chan_onehot got=%b exp=%b", e.tag, chan_onehot, e.oh);
      end
      if (e.chk_adv) begin
         total++;
         assert (adv === e.adv) else begin
            bad++;
            $error("FAIL %s adv got=%b exp=%b", e.tag, adv, e.adv);
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic step_check();
      cyc();
      check_pop();
   endtask

   initial begin
      rst     = 1'b1;
      mode    = 1'b0;
      sel_in  = '0;
      div     = '0;
      en_mask = '0;
      for (int i = 0; i < CHANNELS; i++) din[i*WIDTH +: WIDTH] = lane_val(i);

      @(negedge clk);
      push("reset", 0, 1'b1, 1'b0, 1'b1);
      check_pop();

      // manual select
      rst    = 1'b0;
      sel_in = 3'd5;
      push("man5", 5, 1'b0, 1'b1, 1'b1);
      step_check();
      push("man5_hold", 5, 1'b0, 1'b0, 1'b1);
      step_check();

      sel_in = 3'd0;
      push("man0", 0, 1'b0, 1'b1, 1'b1);
      step_check();

      // auto scan, div=3, all enabled: one step every 4 cycles
      mode    = 1'b1;
      div     = 16'd3;
      en_mask = 8'hFF;
      for (int s = 1; s <= 8; s++) begin
         for (int c = 0; c < 3; c++) begin
            push("auto_wait", (s - 1) % 8, 1'b0, 1'b0, 1'b1);
            step_check();
         end
         push("auto_step", s % 8, 1'b0, 1'b1, 1'b1);
         step_check();
      end

      // sparse mask, advance every cycle
      div     = 16'd0;
      en_mask = 8'b1000_0101;
      seq     = '{2, 7, 0, 2, 7, 0};
      for (int k = 0; k < 6; k++) push("sparse", seq[k], 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 6; k++) step_check();

      // everything masked, then a single channel re-enabled
      en_mask = 8'h00;
      for (int k = 0; k < 2; k++) begin
         push("blank", 0, 1'b1, 1'b0, 1'b1);
         step_check();
      end
      en_mask = 8'h10;
      push("reenable", 4, 1'b0, 1'b1, 1'b1);
      step_check();
      for (int k = 0; k < 3; k++) begin
         push("hold4", 4, 1'b0, 1'b0, 1'b1);
         step_check();
      end

      // auto -> manual, then lower div below the running count
      mode    = 1'b0;
      sel_in  = 3'd0;
      en_mask = 8'hFF;
      push("to_manual", 0, 1'b0, 1'b1, 1'b1);
      step_check();
      mode = 1'b1;
      div  = 16'd100;
      for (int k = 0; k < 50; k++) begin
         push("slow", 0, 1'b0, 1'b0, 1'b1);
         step_check();
      end
      div = 16'd10;
      push("div_lower", 1, 1'b0, 1'b1, 1'b1);
      step_check();
      for (int p = 2; p <= 6; p++) begin
         for (int c = 0; c < 10; c++) begin
            push("div10_wait", p - 1, 1'b0, 1'b0, 1'b1);
            step_check();
         end
         push("div10_step", p, 1'b0, 1'b1, 1'b1);
         step_check();
      end

      // asynchronous reset at sel 6, sampled before the next rising edge
      #2 rst = 1'b1;
      #1;
      push("async_rst", 0, 1'b1, 1'b0, 1'b1);
      check_pop();

      @(negedge clk);
      mode   = 1'b0;
      sel_in = 3'd3;
      rst    = 1'b0;
      push("post_rst", 3, 1'b0, 1'b0, 1'b0);
      step_check();

      // data change on the selected lane shows up one cycle later
      din[3*WIDTH +: WIDTH] = 8'h3C;
      push_raw("lane_track", 3, 8'h3C, 8'b0000_1000, 1'b0, 1'b1);
      step_check();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
